// File: rtl/countdown_capture_pkg.sv
// countdown_capture_pkg
// Shared definitions for the countdown latency capture block: the
// measurement FSM state encoding and the default counter width and
// timeout used by countdown_capture.
package countdown_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_TIMEOUT   = 4095;

endpackage : countdown_capture_pkg

// File: rtl/countdown_capture_sync.sv
// bit_synchronizer
// Multi-flop synchroniser bringing an asynchronous single-bit signal into
// the clk domain. All flops clear to 0 on reset.
// Ports:
//   clk - sampling clock
//   rst - asynchronous active-high reset
//   d   - asynchronous input bit
//   q   - synchronised output, STAGES clocks behind d
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : bit_synchronizer

// File: rtl/countdown_capture.sv
// countdown_capture
// Measures the propagation latency of an external countdown stage: toggles
// launch, then counts clock cycles until the synchronised dout changes away
// from the level it had at launch time, or aborts at TIMEOUT. The result is
// held on a valid/ready interface until accepted.
// Optional build macro:
//   CAPTURE_GLITCH_FILTER_EN - a dout change must persist for two
//   consecutive WAIT cycles before it is accepted.
// Ports:
//   sys_clk     - single clock, all state on the rising edge
//   rst         - asynchronous active-high reset
//   start       - request one measurement (sampled only when idle)
//   dout        - asynchronous output of the stage under measurement
//   launch      - registered level driving the countdown input
//   busy        - high whenever a measurement or result is pending
//   res_valid   - result available
//   res_ready   - consumer accepts the result
//   res_latency - measured cycle count (includes synchroniser delay)
//   res_timeout - measurement aborted at TIMEOUT
module countdown_capture
  import countdown_capture_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dout,
  output logic                 launch,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CNT_WIDTH-1:0] res_latency,
  output logic                 res_timeout
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v >= TIMEOUT_C) ? TIMEOUT_C : v + 1'b1;
  endfunction

  state_e               state_q, state_d;
  logic                 launch_q, launch_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ref_q, ref_d;
  logic [CNT_WIDTH-1:0] lat_q, lat_d;
  logic                 to_q, to_d;
  logic                 dout_sync;
  logic                 diff;
  logic                 accept;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (sys_clk),
    .rst (rst),
    .d   (dout),
    .q   (dout_sync)
  );

`ifdef CAPTURE_GLITCH_FILTER_EN
  // Set after one WAIT cycle with dout differing from ref; a second
  // consecutive differing cycle accepts the change.
  logic pend_q, pend_d;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    launch_d = launch_q;
    cnt_d    = cnt_q;
    ref_d    = ref_q;
    lat_d    = lat_q;
    to_d     = to_q;
    diff     = 1'b0;
    accept   = 1'b0;
`ifdef CAPTURE_GLITCH_FILTER_EN
    pend_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        launch_d = ~launch_q;
        cnt_d    = '0;
        ref_d    = dout_sync;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        diff = (dout_sync != ref_q);
`ifdef CAPTURE_GLITCH_FILTER_EN
        accept = diff & pend_q;
        pend_d = diff;
`else
        accept = diff;
`endif
        // An accepted edge wins over a timeout landing in the same cycle.
        if (accept) begin
          state_d = ST_HOLD;
          lat_d   = cnt_q;
          to_d    = 1'b0;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = ST_HOLD;
          lat_d   = TIMEOUT_C;
          to_d    = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      launch_q <= 1'b0;
      cnt_q    <= '0;
      ref_q    <= 1'b0;
      lat_q    <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      lat_q    <= lat_d;
      to_q     <= to_d;
    end
  end

  assign launch      = launch_q;
  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = (state_q == ST_HOLD);
  assign res_latency = lat_q;
  assign res_timeout = to_q;

endmodule : countdown_capture
